// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, 8-bit ALU, C/Z flags, EX/MEM register
//
// Purpose: sits between ID/EX and MEM. Picks forwarded operands, runs the ALU,
// owns the architectural carry/zero flags, and registers results into EX/MEM.
// The EX/MEM register and flags freeze on stall; flush loads a bubble.
//
// Optional build macro: EX_OVF_FLAG_EN adds a signed-overflow flag (flag_v).
//
// Ports:
//   clk, reset (async, active low)
//   ID_EX_*           decoded instruction, operands and controls from ID/EX
//   fwd_a_sel/b_sel   00/11 ID/EX value, 01 EX_MEM_result, 10 wb_data
//   wb_data           write-back value for forwarding
//   stall, flush      pipeline hold / bubble insert (stall has priority)
//   EX_MEM_*          registered outputs to the MEM stage
//   flag_c, flag_z    architectural flags (flag_v when EX_OVF_FLAG_EN)
`timescale 1ns/1ps
module ex_stage #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  ID_EX_A,
  input  logic [DATA_W-1:0]  ID_EX_B,
  input  logic [INSTR_W-1:0] ID_EX_instruction,
  input  logic               ID_EX_mem_write,
  input  logic               ID_EX_reg_write,
  input  logic               ID_EX_alu_use_carry,
  input  logic               ID_EX_alu_in_mux,
  input  logic               ID_EX_select_c,
  input  logic               ID_EX_select_z,
  input  logic               ID_EX_write_c,
  input  logic               ID_EX_write_z,
  input  logic [2:0]         ID_EX_alu_op,
  input  logic [1:0]         ID_EX_reg_write_mux,
  input  logic [1:0]         fwd_a_sel,
  input  logic [1:0]         fwd_b_sel,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               stall,
  input  logic               flush,
  output logic [DATA_W-1:0]  EX_MEM_result,
  output logic [DATA_W-1:0]  EX_MEM_B,
  output logic [INSTR_W-1:0] EX_MEM_instruction,
  output logic               EX_MEM_mem_write,
  output logic               EX_MEM_reg_write,
  output logic [1:0]         EX_MEM_reg_write_mux,
  output logic               flag_c,
  output logic               flag_z
`ifdef EX_OVF_FLAG_EN
  ,
  output logic               flag_v
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ROL = 3'b111;

  localparam logic [3:0] LP_W = 4'(DATA_W);

  logic [DATA_W-1:0]  r_result;
  logic [DATA_W-1:0]  r_b;
  logic [INSTR_W-1:0] r_instr;
  logic               r_mem_write;
  logic               r_reg_write;
  logic [1:0]         r_reg_write_mux;
  logic               r_c;
  logic               r_z;

  logic [DATA_W-1:0]  w_op_a;
  logic [DATA_W-1:0]  w_fwd_b;
  logic [DATA_W-1:0]  w_op_b;
  logic [2:0]         w_sh;
  logic               w_cin;
  logic               w_bin;
  logic [DATA_W:0]    w_sum;
  logic [DATA_W:0]    w_diff;
  logic [DATA_W:0]    w_shl;
  logic [DATA_W:0]    w_shr;
  logic [DATA_W-1:0]  w_res;
  logic               w_carry;
  logic               w_zero;
  logic               w_next_c;
  logic               w_next_z;

  // Forwarding taps the pre-edge EX_MEM_result, so dependent ops need no bubble.
  always_comb begin
    w_op_a = ID_EX_A;
    case (fwd_a_sel)
      2'b01:   w_op_a = r_result;
      2'b10:   w_op_a = wb_data;
      default: w_op_a = ID_EX_A;
    endcase
    w_fwd_b = ID_EX_B;
    case (fwd_b_sel)
      2'b01:   w_fwd_b = r_result;
      2'b10:   w_fwd_b = wb_data;
      default: w_fwd_b = ID_EX_B;
    endcase
  end

  assign w_op_b = ID_EX_alu_in_mux ? ID_EX_instruction[DATA_W-1:0] : w_fwd_b;
  assign w_sh   = ID_EX_instruction[2:0];
  assign w_cin  = ID_EX_alu_use_carry & r_c;
  assign w_bin  = ID_EX_alu_use_carry & ~r_c;

  // One extra bit on each side of the shifters catches the last bit shifted out.
  assign w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b} + {{DATA_W{1'b0}}, w_cin};
  assign w_diff = {1'b0, w_op_a} - {1'b0, w_op_b} - {{DATA_W{1'b0}}, w_bin};
  assign w_shl  = {1'b0, w_op_a} << w_sh;
  assign w_shr  = {w_op_a, 1'b0} >> w_sh;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (ID_EX_alu_op)
      OP_ADD: begin
        w_res   = w_sum[DATA_W-1:0];
        w_carry = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_res   = w_diff[DATA_W-1:0];
        w_carry = ~w_diff[DATA_W];  // C=1 means no borrow
      end
      OP_AND: w_res = w_op_a & w_op_b;
      OP_OR:  w_res = w_op_a | w_op_b;
      OP_XOR: w_res = w_op_a ^ w_op_b;
      OP_SHL: begin
        w_res   = w_shl[DATA_W-1:0];
        w_carry = (w_sh == 3'd0) ? r_c : w_shl[DATA_W];
      end
      OP_SHR: begin
        w_res   = w_shr[DATA_W:1];
        w_carry = (w_sh == 3'd0) ? r_c : w_shr[0];
      end
      OP_ROL: begin
        // sh=0 makes the right-shift term a full-width shift, i.e. zero.
        w_res   = (w_op_a << w_sh) | (w_op_a >> (LP_W - {1'b0, w_sh}));
        w_carry = w_res[0];
      end
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
      end
    endcase
  end

  assign w_zero   = (w_res == '0);
  assign w_next_c = ID_EX_write_c ? (ID_EX_select_c ? w_carry : ID_EX_instruction[0]) : r_c;
  assign w_next_z = ID_EX_write_z ? (ID_EX_select_z ? w_zero  : ID_EX_instruction[1]) : r_z;

`ifdef EX_OVF_FLAG_EN
  logic r_v;
  logic w_ovf;
  logic w_v_upd;

  // Signed overflow: operands (after subtrahend inversion for SUB) share a sign
  // that the result does not.
  always_comb begin
    w_ovf = 1'b0;
    if (ID_EX_alu_op == OP_ADD)
      w_ovf = (w_op_a[DATA_W-1] == w_op_b[DATA_W-1]) & (w_res[DATA_W-1] != w_op_a[DATA_W-1]);
    else if (ID_EX_alu_op == OP_SUB)
      w_ovf = (w_op_a[DATA_W-1] != w_op_b[DATA_W-1]) & (w_res[DATA_W-1] != w_op_a[DATA_W-1]);
  end

  assign w_v_upd = ID_EX_write_c & ID_EX_select_c &
                   ((ID_EX_alu_op == OP_ADD) | (ID_EX_alu_op == OP_SUB));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_v <= 1'b0;
    else if (!stall && !flush && w_v_upd)
      r_v <= w_ovf;
  end

  assign flag_v = r_v;
`endif

  // Stall outranks flush: a flush seen during a stall is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result        <= '0;
      r_b             <= '0;
      r_instr         <= '0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
      r_reg_write_mux <= '0;
      r_c             <= 1'b0;
      r_z             <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        r_result        <= '0;
        r_b             <= '0;
        r_instr         <= '0;
        r_mem_write     <= 1'b0;
        r_reg_write     <= 1'b0;
        r_reg_write_mux <= '0;
      end else begin
        r_result        <= w_res;
        r_b             <= w_fwd_b;
        r_instr         <= ID_EX_instruction;
        r_mem_write     <= ID_EX_mem_write;
        r_reg_write     <= ID_EX_reg_write;
        r_reg_write_mux <= ID_EX_reg_write_mux;
        r_c             <= w_next_c;
        r_z             <= w_next_z;
      end
    end
  end

  assign EX_MEM_result        = r_result;
  assign EX_MEM_B             = r_b;
  assign EX_MEM_instruction   = r_instr;
  assign EX_MEM_mem_write     = r_mem_write;
  assign EX_MEM_reg_write     = r_reg_write;
  assign EX_MEM_reg_write_mux = r_reg_write_mux;
  assign flag_c               = r_c;
  assign flag_z               = r_z;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  ID_EX_A, ID_EX_B, wb_data;
  logic [18:0] ID_EX_instruction;
  logic        ID_EX_mem_write, ID_EX_reg_write, ID_EX_alu_use_carry, ID_EX_alu_in_mux;
  logic        ID_EX_select_c, ID_EX_select_z, ID_EX_write_c, ID_EX_write_z;
  logic [2:0]  ID_EX_alu_op;
  logic [1:0]  ID_EX_reg_write_mux, fwd_a_sel, fwd_b_sel;
  logic        stall, flush;
  logic [7:0]  EX_MEM_result, EX_MEM_B;
  logic [18:0] EX_MEM_instruction;
  logic        EX_MEM_mem_write, EX_MEM_reg_write;
  logic [1:0]  EX_MEM_reg_write_mux;
  logic        flag_c, flag_z;
`ifdef EX_OVF_FLAG_EN
  logic        flag_v;
`endif

  ex_stage #(.DATA_W(8), .INSTR_W(19)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_instruction(ID_EX_instruction),
    .ID_EX_mem_write(ID_EX_mem_write), .ID_EX_reg_write(ID_EX_reg_write),
    .ID_EX_alu_use_carry(ID_EX_alu_use_carry), .ID_EX_alu_in_mux(ID_EX_alu_in_mux),
    .ID_EX_select_c(ID_EX_select_c), .ID_EX_select_z(ID_EX_select_z),
    .ID_EX_write_c(ID_EX_write_c), .ID_EX_write_z(ID_EX_write_z),
    .ID_EX_alu_op(ID_EX_alu_op), .ID_EX_reg_write_mux(ID_EX_reg_write_mux),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .wb_data(wb_data),
    .stall(stall), .flush(flush),
    .EX_MEM_result(EX_MEM_result), .EX_MEM_B(EX_MEM_B),
    .EX_MEM_instruction(EX_MEM_instruction),
    .EX_MEM_mem_write(EX_MEM_mem_write), .EX_MEM_reg_write(EX_MEM_reg_write),
    .EX_MEM_reg_write_mux(EX_MEM_reg_write_mux),
    .flag_c(flag_c), .flag_z(flag_z)
`ifdef EX_OVF_FLAG_EN
    , .flag_v(flag_v)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, XOR_ = 3'd4;
  localparam logic [2:0] SHL = 3'd5, SHR = 3'd6, ROL = 3'd7;

  typedef struct {
    string       nm;
    logic [7:0]  res;
    logic [7:0]  b;
    logic [18:0] ins;
    logic        mw;
    logic        rw;
    logic [1:0]  rwm;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
    end
  endtask

  task automatic cmp_entry(input exp_t e);
    vectors++;
    cmp(e.nm, "result", 32'(EX_MEM_result), 32'(e.res));
    cmp(e.nm, "B", 32'(EX_MEM_B), 32'(e.b));
    cmp(e.nm, "instr", 32'(EX_MEM_instruction), 32'(e.ins));
    cmp(e.nm, "mem_write", 32'(EX_MEM_mem_write), 32'(e.mw));
    cmp(e.nm, "reg_write", 32'(EX_MEM_reg_write), 32'(e.rw));
    cmp(e.nm, "reg_write_mux", 32'(EX_MEM_reg_write_mux), 32'(e.rwm));
    cmp(e.nm, "flag_c", 32'(flag_c), 32'(e.c));
    cmp(e.nm, "flag_z", 32'(flag_z), 32'(e.z));
`ifdef EX_OVF_FLAG_EN
    cmp(e.nm, "flag_v", 32'(flag_v), 32'(e.v));
`endif
  endtask

  // Monitor: every registered output set is checked mid-cycle against the queue head.
  always @(negedge clk) begin
    if (q.size() > 0) cmp_entry(q.pop_front());
  end

  task automatic clr();
    ID_EX_A = 8'h00; ID_EX_B = 8'h00; wb_data = 8'h00; ID_EX_instruction = 19'h0;
    ID_EX_mem_write = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_alu_use_carry = 1'b0;
    ID_EX_alu_in_mux = 1'b0; ID_EX_select_c = 1'b0; ID_EX_select_z = 1'b0;
    ID_EX_write_c = 1'b0; ID_EX_write_z = 1'b0; ID_EX_alu_op = ADD;
    ID_EX_reg_write_mux = 2'b00; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic flags_all();
    ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1; ID_EX_select_c = 1'b1; ID_EX_select_z = 1'b1;
  endtask

  // Apply one edge; pass-through fields come from the driven inputs (zero on flush).
  task automatic go(input string nm, input logic [7:0] r, input logic [7:0] b,
                    input logic c, input logic z, input logic v);
    exp_t e;
    e.nm = nm; e.res = r; e.b = b; e.c = c; e.z = z; e.v = v;
    e.ins = flush ? 19'h0 : ID_EX_instruction;
    e.mw  = flush ? 1'b0 : ID_EX_mem_write;
    e.rw  = flush ? 1'b0 : ID_EX_reg_write;
    e.rwm = flush ? 2'b00 : ID_EX_reg_write_mux;
    @(posedge clk); #1;
    q.push_back(e);
    last = e;
  endtask

  task automatic hold(input string nm);
    exp_t e;
    e = last; e.nm = nm;
    @(posedge clk); #1;
    q.push_back(e);
  endtask

  initial begin
    exp_t z0;
    clr();
    z0.nm = "reset"; z0.res = 8'h00; z0.b = 8'h00; z0.ins = 19'h0; z0.mw = 1'b0;
    z0.rw = 1'b0; z0.rwm = 2'b00; z0.c = 1'b0; z0.z = 1'b0; z0.v = 1'b0;
    q.push_back(z0);
    last = z0;
    @(negedge clk); #2;
    reset = 1'b1;

    clr(); ID_EX_A = 8'hFF; ID_EX_B = 8'h01; flags_all();
    ID_EX_instruction = 19'h4_0000; ID_EX_reg_write = 1'b1; ID_EX_reg_write_mux = 2'b01;
    go("add_wrap", 8'h00, 8'h01, 1'b1, 1'b1, 1'b0);

    clr(); ID_EX_A = 8'h10; ID_EX_B = 8'h33; ID_EX_instruction = 19'h1_0005;
    ID_EX_alu_in_mux = 1'b1; ID_EX_alu_use_carry = 1'b1; ID_EX_write_z = 1'b1; ID_EX_select_z = 1'b1;
    go("adc_imm", 8'h16, 8'h33, 1'b1, 1'b0, 1'b0);

    clr(); ID_EX_A = 8'h00; ID_EX_B = 8'h01; ID_EX_alu_op = SUB; ID_EX_alu_use_carry = 1'b1;
    flags_all(); ID_EX_mem_write = 1'b1;
    go("sbc_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);

    clr(); ID_EX_A = 8'h03; ID_EX_B = 8'h04; ID_EX_reg_write_mux = 2'b10;
    go("add_3_4", 8'h07, 8'h04, 1'b0, 1'b0, 1'b0);

    clr(); fwd_a_sel = 2'b01; ID_EX_A = 8'h55; ID_EX_B = 8'h0F; ID_EX_alu_op = XOR_;
    go("xor_fwd_a", 8'h08, 8'h0F, 1'b0, 1'b0, 1'b0);

    clr(); fwd_a_sel = 2'b01; fwd_b_sel = 2'b10; wb_data = 8'hAA; ID_EX_B = 8'h0F; ID_EX_alu_op = XOR_;
    go("xor_fwd_wb", 8'hA2, 8'hAA, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      clr(); stall = 1'b1; ID_EX_A = 8'(i * 37 + 1); ID_EX_B = 8'hFF; flags_all();
      ID_EX_reg_write = 1'b1; ID_EX_mem_write = 1'b1; ID_EX_instruction = 19'(i + 7);
      hold("stall");
    end

    clr(); stall = 1'b1; flush = 1'b1; ID_EX_A = 8'h12; flags_all();
    hold("stall_flush");

    clr(); flush = 1'b1; ID_EX_A = 8'hFF; ID_EX_B = 8'h01; ID_EX_reg_write = 1'b1;
    ID_EX_mem_write = 1'b1; ID_EX_write_c = 1'b1; ID_EX_select_c = 1'b1; ID_EX_instruction = 19'h3;
    go("flush", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    clr(); ID_EX_A = 8'h05; ID_EX_B = 8'h05; ID_EX_alu_op = SUB; flags_all();
    go("sub_eq", 8'h00, 8'h05, 1'b1, 1'b1, 1'b0);

    clr(); ID_EX_A = 8'h81; ID_EX_instruction = 19'h1; ID_EX_alu_op = SHL; flags_all();
    go("shl_1", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);

    clr(); ID_EX_A = 8'h01; ID_EX_instruction = 19'h1; ID_EX_alu_op = SHR; flags_all();
    go("shr_1", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    clr(); ID_EX_A = 8'h81; ID_EX_instruction = 19'h1; ID_EX_alu_op = ROL; flags_all();
    go("rol_1", 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);

    clr(); ID_EX_A = 8'hFF; ID_EX_B = 8'h0F; ID_EX_alu_op = AND_; ID_EX_instruction = 19'h2;
    ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    go("literal_flags", 8'h0F, 8'h0F, 1'b0, 1'b1, 1'b0);

    clr(); ID_EX_A = 8'h40; ID_EX_instruction = 19'h2; ID_EX_alu_op = SHL; flags_all();
    go("shl_2", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    clr(); ID_EX_A = 8'h40; ID_EX_instruction = 19'h0; ID_EX_alu_op = SHL; flags_all();
    go("shl_0_keep_c", 8'h40, 8'h00, 1'b1, 1'b0, 1'b0);

    clr(); ID_EX_A = 8'h7F; ID_EX_B = 8'h01; flags_all();
    go("add_ovf", 8'h80, 8'h01, 1'b0, 1'b0, 1'b1);

    clr(); ID_EX_A = 8'h01; ID_EX_B = 8'h00; fwd_b_sel = 2'b01;
    go("add_fwd_b", 8'h81, 8'h80, 1'b0, 1'b0, 1'b1);

    clr(); stall = 1'b1; ID_EX_A = 8'hFF; ID_EX_B = 8'hFF; flags_all();
    hold("stall_pre_reset");

    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    z0.nm = "async_reset";
    cmp_entry(z0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    miscompares++;
    $display("FAIL watchdog actual=timeout required=done");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
